// File: rtl/pu_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : pu_input_packer
// Purpose  : Packs a row-major operand stream into NUM_PE-lane words for the
//            PU, one output register with read-request bypass.
// Revision : 1.0 - initial release
// ============================================================================
module pu_input_packer #(
   parameter  int OP_WIDTH   = 16,
   parameter  int NUM_PE     = 4,
   parameter  int DIM_WIDTH  = 16,
   localparam int DATA_WIDTH = OP_WIDTH * NUM_PE
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [DIM_WIDTH-1:0]  cfg_row_width,
   input  logic [DIM_WIDTH-1:0]  cfg_num_rows,
   input  logic                  in_valid,
   input  logic [OP_WIDTH-1:0]   in_data,
   output logic                  in_ready,
   input  logic                  pu_rd_req,
   output logic                  pu_rd_ready,
   output logic [DATA_WIDTH-1:0] pu_data_in,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_underflow
);

   localparam int c_LANE_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
   localparam logic [c_LANE_W-1:0] c_LAST_LANE = c_LANE_W'(NUM_PE - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                r_state, w_state_next;
   logic [DIM_WIDTH-1:0]  r_w, r_h, r_col, r_row;
   logic [c_LANE_W-1:0]   r_lane;
   logic [DATA_WIDTH-1:0] r_pack, r_out, w_word;
   logic                  r_out_valid, r_done, r_underflow;
   logic                  w_dims_ok, w_row_end, w_word_last, w_frame_last;
   logic                  w_in_ready, w_accept, w_xfer;

   assign w_dims_ok    = (cfg_row_width != '0) && (cfg_num_rows != '0);
   assign w_row_end    = (r_col == r_w - DIM_WIDTH'(1));
   assign w_word_last  = (r_lane == c_LAST_LANE) || w_row_end;
   assign w_frame_last = w_row_end && (r_row == r_h - DIM_WIDTH'(1));
   assign w_xfer       = pu_rd_req && r_out_valid;
   // A completing operand needs the output register free, or freed this cycle.
   assign w_in_ready   = (r_state == ST_FILL) && !(w_word_last && r_out_valid && !pu_rd_req);
   assign w_accept     = in_valid && w_in_ready;

   // Lanes above the current one are already zero because r_pack is cleared per word.
   always_comb begin
      w_word = r_pack;
      for (int i = 0; i < NUM_PE; i++) begin
         if (r_lane == c_LANE_W'(i)) begin
            w_word[i*OP_WIDTH +: OP_WIDTH] = in_data;
         end
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE:  if (start && w_dims_ok)         w_state_next = ST_FILL;
         ST_FILL:  if (w_accept && w_frame_last)   w_state_next = ST_DRAIN;
         ST_DRAIN: if (w_xfer)                     w_state_next = ST_IDLE;
         default:                                  w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_w         <= '0;
         r_h         <= '0;
         r_col       <= '0;
         r_row       <= '0;
         r_lane      <= '0;
         r_pack      <= '0;
         r_out       <= '0;
         r_out_valid <= 1'b0;
         r_done      <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_done <= ((r_state == ST_IDLE) && start && !w_dims_ok) ||
                   ((r_state == ST_DRAIN) && w_xfer);

         if ((r_state == ST_IDLE) && start) begin
            r_underflow <= 1'b0;
            r_w         <= cfg_row_width;
            r_h         <= cfg_num_rows;
            r_col       <= '0;
            r_row       <= '0;
            r_lane      <= '0;
            r_pack      <= '0;
         end else begin
            if (pu_rd_req && !r_out_valid) begin
               r_underflow <= 1'b1;
            end
            if (w_accept) begin
               r_pack <= w_word_last ? '0 : w_word;
               if (w_row_end) begin
                  r_lane <= '0;
                  r_col  <= '0;
                  r_row  <= r_row + DIM_WIDTH'(1);
               end else begin
                  r_lane <= (r_lane == c_LAST_LANE) ? '0 : r_lane + c_LANE_W'(1);
                  r_col  <= r_col + DIM_WIDTH'(1);
               end
            end
         end

         if (w_accept && w_word_last) begin
            r_out       <= w_word;
            r_out_valid <= 1'b1;
         end else if (w_xfer) begin
            r_out_valid <= 1'b0;
         end
      end
   end

   assign in_ready     = w_in_ready;
   assign pu_rd_ready  = r_out_valid;
   assign pu_data_in   = r_out;
   assign busy         = (r_state != ST_IDLE);
   assign done         = r_done;
   assign rd_underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_pu_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pu_input_packer
// Purpose  : Self-checking bench for pu_input_packer against a word-list model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pu_input_packer;

   localparam int OPW = 16;
   localparam int NPE = 4;
   localparam int DW  = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          start = 1'b0;
   logic [DW-1:0] cfg_row_width = '0;
   logic [DW-1:0] cfg_num_rows = '0;
   logic          in_valid = 1'b0;
   logic [OPW-1:0] in_data = '0;
   logic          in_ready;
   logic          pu_rd_req = 1'b0;
   logic          pu_rd_ready;
   logic [OPW*NPE-1:0] pu_data_in;
   logic          busy, done, rd_underflow;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pu_input_packer #(.OP_WIDTH(OPW), .NUM_PE(NPE), .DIM_WIDTH(DW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .cfg_row_width(cfg_row_width), .cfg_num_rows(cfg_num_rows),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .pu_rd_req(pu_rd_req), .pu_rd_ready(pu_rd_ready), .pu_data_in(pu_data_in),
      .busy(busy), .done(done), .rd_underflow(rd_underflow)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " in_ready"},     in_ready, 0);
      check({tag, " pu_rd_ready"},  pu_rd_ready, 0);
      check({tag, " busy"},         busy, 0);
      check({tag, " done"},         done, 0);
      check({tag, " rd_underflow"}, rd_underflow, 0);
      check({tag, " pu_data_in"},   pu_data_in, 0);
   endtask

   // Runs one frame; the expected word list is built from W, H and the operand list.
   task automatic run_frame(input int w, input int h, input bit seq, input int vprob,
                            input int rprob, input int stall, input bit no_stall_chk);
      logic [OPW-1:0]     data[$];
      logic [OPW*NPE-1:0] exp_q[$];
      logic [OPW*NPE-1:0] word, prev_data;
      int  n, idx, widx, cyc;
      bit  fin, fin_next, prev_hold, acc, xf;
      n = w * h;
      for (int i = 0; i < n; i++) data.push_back(seq ? OPW'(i) : OPW'($urandom));
      for (int r = 0; r < h; r++) begin
         for (int c = 0; c < w; c += NPE) begin
            word = '0;
            for (int k = 0; k < NPE && c + k < w; k++) word[k*OPW +: OPW] = data[r*w + c + k];
            exp_q.push_back(word);
         end
      end
      start = 1'b1; cfg_row_width = DW'(w); cfg_num_rows = DW'(h);
      in_valid = 1'b0; pu_rd_req = 1'b0;
      tick();
      start = 1'b0;
      check("busy after start", busy, 1);
      idx = 0; widx = 0; cyc = 0; fin = 0; fin_next = 0; prev_hold = 0; prev_data = '0;
      while (!fin && cyc < 3000) begin
         in_valid  = (idx < n) && ($urandom_range(99) < vprob);
         in_data   = (idx < n) ? data[idx] : OPW'($urandom);
         pu_rd_req = (cyc < stall) ? 1'b0 : ($urandom_range(99) < rprob);
         // Mid-frame start and config churn must be ignored.
         start         = (idx < n) && ($urandom_range(9) == 0);
         cfg_row_width = DW'($urandom_range(3));
         cfg_num_rows  = DW'($urandom_range(3));
         @(negedge clk);
         if (prev_hold) begin
            check("held word stable", pu_data_in, prev_data);
            check("held ready", pu_rd_ready, 1);
         end
         if (stall > 0 && cyc == stall - 1) begin
            check("stall accepted count", idx, 7);
            check("stall in_ready low", in_ready, 0);
            check("stall word held", pu_rd_ready, 1);
         end
         check("done timing", done, fin_next);
         if (fin_next) begin
            check("busy at done", busy, 0);
            check("operands consumed", idx, n);
            fin = 1;
         end
         if (no_stall_chk && idx < n) check("in_ready continuous", in_ready, 1);
         acc = in_valid && in_ready;
         xf  = pu_rd_req && pu_rd_ready;
         if (xf) begin
            if (widx < exp_q.size()) check($sformatf("word %0d", widx), pu_data_in, exp_q[widx]);
            else check("extra word", 1, 0);
            widx++;
            if (widx == exp_q.size()) fin_next = 1;
         end
         prev_hold = pu_rd_ready && !pu_rd_req;
         prev_data = pu_data_in;
         if (acc) idx++;
         tick();
         cyc++;
      end
      if (!fin) check("frame timeout", 0, 1);
      start = 1'b0; in_valid = 1'b0; pu_rd_req = 1'b0;
      tick();
   endtask

   initial begin
      // Reset state
      #2;
      check_all_zero("reset");
      tick(); tick();
      reset_n = 1'b1;
      tick();
      check_all_zero("post reset");

      // Sticky underflow, cleared by a zero-dimension start
      pu_rd_req = 1'b1;
      tick();
      pu_rd_req = 1'b0;
      check("underflow set", rd_underflow, 1);
      tick(); tick();
      check("underflow sticky", rd_underflow, 1);
      start = 1'b1; cfg_row_width = '0; cfg_num_rows = DW'(3);
      tick();
      start = 1'b0;
      check("zero W done", done, 1);
      check("zero W busy", busy, 0);
      check("zero W ready", pu_rd_ready, 0);
      check("underflow cleared", rd_underflow, 0);
      tick();
      check("zero W done once", done, 0);
      check("zero W no word", pu_rd_ready, 0);
      start = 1'b1; cfg_row_width = DW'(4); cfg_num_rows = '0;
      tick();
      start = 1'b0;
      check("zero H done", done, 1);
      check("zero H busy", busy, 0);
      tick();
      check("zero H no word", pu_rd_ready, 0);

      // Basic ragged-row frame, sequential data
      run_frame(5, 2, 1'b1, 100, 100, 0, 1'b1);
      // Full-width rows, back-to-back
      run_frame(8, 1, 1'b1, 100, 100, 0, 1'b1);
      // Consumer stall for 10 cycles
      run_frame(4, 3, 1'b0, 100, 100, 10, 1'b0);

      // Abort mid-frame after 3 operands
      start = 1'b1; cfg_row_width = DW'(5); cfg_num_rows = DW'(2);
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = OPW'(100 + i);
         tick();
      end
      in_valid = 1'b0;
      reset_n = 1'b0;
      #1;
      check_all_zero("mid-frame reset");
      tick();
      reset_n = 1'b1;
      tick();
      check_all_zero("after abort");
      run_frame(5, 2, 1'b1, 100, 100, 0, 1'b1);

      // Randomized frames with random valid/request patterns
      for (int t = 0; t < 8; t++) begin
         run_frame($urandom_range(11, 1), $urandom_range(4, 1), 1'b0,
                   $urandom_range(90, 30), $urandom_range(90, 30), 0, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
